// File: rtl/coin_pkg.sv
// Shared constants, coin word type and arbiter state encoding for the coin sharing block.
package coin_pkg;
  localparam int unsigned COIN_W = 16;
  localparam int unsigned LEN_W  = 10;

  typedef logic [COIN_W-1:0] coin_t;

  typedef enum logic [1:0] {IDLE, BURST, DONE} arb_state_t;
endpackage

// File: rtl/coin_fifo.sv
// Synchronous FIFO fed by the free-running coin source; a push at full is taken only
// when a pop frees a slot in the same cycle, otherwise the word is dropped.
module coin_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] hold;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Remember the visible head so the output holds its last value once drained.
      if (!empty) hold <= mem[rd_ptr];
    end
  end

  assign head = empty ? hold : mem[rd_ptr];
endmodule

// File: rtl/coin_arbiter.sv
// Round-robin burst arbiter sharing one coin source among NUM_REQ samplers.
// Define COIN_CNT_EN to add the coin_cnt output (words handed out since reset).
module coin_arbiter
  import coin_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned COIN_W  = coin_pkg::COIN_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEN_W   = coin_pkg::LEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COIN_W-1:0]        coin_in,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [COIN_W-1:0]        coin_out,
  output logic                     coin_valid,
  input  logic                     coin_ready,
  output logic                     burst_done
`ifdef COIN_CNT_EN
  ,
  output logic [31:0]              coin_cnt
`endif
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    sel_next;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    idx;
  logic [LEN_W-1:0] remaining;
  logic [CW-1:0]    count;
  logic             found;
  logic             handshake;

  coin_fifo #(
    .WIDTH (COIN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (1'b1),
    .pop   (handshake),
    .din   (coin_in),
    .head  (coin_out),
    .count (count)
  );

  always_comb begin
    state_next = state;
    sel_next   = sel;
    idx        = '0;
    found      = 1'b0;
    grant      = '0;
    coin_valid = 1'b0;
    handshake  = 1'b0;
    burst_done = 1'b0;
    unique case (state)
      IDLE: begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          idx = IW'((32'(rr_ptr) + k) % NUM_REQ);
          if (!found && req[idx]) begin
            found    = 1'b1;
            sel_next = idx;
          end
        end
        if (found) state_next = BURST;
      end
      BURST: begin
        grant[sel] = 1'b1;
        coin_valid = (count != '0) && (remaining != '0);
        handshake  = coin_valid && coin_ready;
        // remaining is only zero here for a zero-length request.
        if (remaining == '0 || (handshake && remaining == LEN_W'(1))) begin
          burst_done = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      if (state == IDLE && found)
        remaining <= req_len[32'(sel_next)*LEN_W +: LEN_W];
      else if (handshake)
        remaining <= remaining - 1'b1;
      if (state == DONE)
        rr_ptr <= (32'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
    end
  end

`ifdef COIN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)            coin_cnt <= '0;
    else if (handshake) coin_cnt <= coin_cnt + 32'd1;
  end
`endif
endmodule
